// File: rtl/hbm_rd_arb_pkg.sv
// Shared types, tag constants and width helpers for the HBM read-address arbiter.
package hbm_rd_arb_pkg;

  localparam int unsigned ArAddrW = 33;
  localparam int unsigned ArIdW   = 6;
  localparam int unsigned ArLenW  = 4;

  // Requester tags carried in the low ARID bits.
  localparam int unsigned MEM_RD_A_TAG = 1;
  localparam int unsigned MEM_RD_B_TAG = 2;

  function automatic int unsigned sel_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned uid_w(input int unsigned id_width, input int unsigned num_req);
    return id_width - sel_w(num_req);
  endfunction

  typedef struct packed {
    logic [ArAddrW-1:0] addr;
    logic [ArIdW-1:0]   id;
    logic [ArLenW-1:0]  len;
  } ar_req_t;

endpackage

// File: rtl/hbm_rd_arb_if.sv
// Bundles the requester AR channels, downstream AR channel and R-channel taps of the arbiter.
interface hbm_rd_arb_if
  import hbm_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 33,
  parameter int unsigned ID_WIDTH   = 6
) ();

  localparam int unsigned UidW = uid_w(ID_WIDTH, NUM_REQ);

  logic [NUM_REQ-1:0]            s_axi_ARVALID;
  logic [NUM_REQ-1:0]            s_axi_ARREADY;
  logic [NUM_REQ*ADDR_WIDTH-1:0] s_axi_ARADDR;
  logic [NUM_REQ*UidW-1:0]       s_axi_ARID;
  logic [NUM_REQ*4-1:0]          s_axi_ARLEN;

  logic                          m_axi_ARVALID;
  logic                          m_axi_ARREADY;
  logic [ADDR_WIDTH-1:0]         m_axi_ARADDR;
  logic [ID_WIDTH-1:0]           m_axi_ARID;
  logic [3:0]                    m_axi_ARLEN;

  logic                          m_axi_RVALID;
  logic                          m_axi_RREADY;
  logic                          m_axi_RLAST;
  logic [ID_WIDTH-1:0]           m_axi_RID;

  // Arbiter side.
  modport master (
    input  s_axi_ARVALID, s_axi_ARADDR, s_axi_ARID, s_axi_ARLEN,
    output s_axi_ARREADY,
    output m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN,
    input  m_axi_ARREADY,
    input  m_axi_RVALID, m_axi_RREADY, m_axi_RLAST, m_axi_RID
  );

  // Requesters plus HBM controller side.
  modport slave (
    output s_axi_ARVALID, s_axi_ARADDR, s_axi_ARID, s_axi_ARLEN,
    input  s_axi_ARREADY,
    input  m_axi_ARVALID, m_axi_ARADDR, m_axi_ARID, m_axi_ARLEN,
    output m_axi_ARREADY,
    output m_axi_RVALID, m_axi_RREADY, m_axi_RLAST, m_axi_RID
  );

endinterface

// File: rtl/hbm_rd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above ptr, with wrap.
module rr_pick
  import hbm_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned SelW   = sel_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SelW-1:0]    ptr,
  output logic [SelW-1:0]    grant_idx,
  output logic               any_grant
);

  logic [SelW-1:0] idx;

  // Scan farthest-first so the closest hit to ptr overwrites the result last.
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + SelW'(k);
      if (req[idx]) begin
        grant_idx = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// Round-robin AR arbiter for one HBM pseudo-channel with per-requester credit limiting.
// Optional grant statistics are built when HBM_RD_ARB_STATS_EN is defined.
module hbm_rd_arbiter
  import hbm_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = ArAddrW,
  parameter int unsigned ID_WIDTH        = ArIdW,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                   hbm_clk,
  input  logic                   hbm_rst,
  hbm_rd_arb_if.master           ar,
  input  logic                   stats_clr,
  output logic                   credit_err,
  output logic [NUM_REQ*32-1:0]  grant_cnt
);

  localparam int unsigned SelW = sel_w(NUM_REQ);
  localparam int unsigned UidW = uid_w(ID_WIDTH, NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  // The output register uses the package struct, so widths must agree with it.
  if (ADDR_WIDTH != ArAddrW || ID_WIDTH != ArIdW) begin : g_width_check
    $error("hbm_rd_arbiter: ADDR_WIDTH/ID_WIDTH must match ar_req_t");
  end

  logic [SelW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]    out_cnt_q [NUM_REQ];
  logic [CntW-1:0]    out_cnt_d [NUM_REQ];
  logic               out_vld_q, out_vld_d;
  ar_req_t            out_q, out_d, sel_req;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] cnt_inc, cnt_dec;
  logic [SelW-1:0]    gnt_idx;
  logic               any_elig;
  logic               stage_open;
  logic               grant;
  logic               r_fire;
  logic [SelW-1:0]    r_sel;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = ar.s_axi_ARVALID[i] && (out_cnt_q[i] < CntW'(MAX_OUTSTANDING));
    end
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant_idx (gnt_idx),
    .any_grant (any_elig)
  );

  assign stage_open = ~out_vld_q | ar.m_axi_ARREADY;
  // No accepts while reset is held, so requesters never lose a burst to reset.
  assign grant      = stage_open & any_elig & ~hbm_rst;

  assign r_fire = ar.m_axi_RVALID & ar.m_axi_RREADY & ar.m_axi_RLAST;
  assign r_sel  = ar.m_axi_RID[ID_WIDTH-1 -: SelW];

  logic unused_rid_low;
  assign unused_rid_low = ^ar.m_axi_RID[UidW-1:0];

  always_comb begin
    sel_req      = '0;
    sel_req.addr = ar.s_axi_ARADDR[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    sel_req.id   = {gnt_idx, ar.s_axi_ARID[gnt_idx*UidW +: UidW]};
    sel_req.len  = ar.s_axi_ARLEN[gnt_idx*4 +: 4];
  end

  always_comb begin
    ar.s_axi_ARREADY = '0;
    if (grant) begin
      ar.s_axi_ARREADY[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_inc[i] = grant && (gnt_idx == SelW'(i));
      cnt_dec[i] = r_fire && (r_sel == SelW'(i));
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
    end

    if (stage_open) begin
      out_vld_d = grant;
      if (grant) begin
        out_d    = sel_req;
        rr_ptr_d = gnt_idx + 1'b1;
      end
    end

    // Simultaneous take and release cancel out.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cnt_inc[i] && !cnt_dec[i]) begin
        out_cnt_d[i] = out_cnt_q[i] + 1'b1;
      end else if (cnt_dec[i] && !cnt_inc[i]) begin
        if (out_cnt_q[i] == '0) begin
          err_d = 1'b1;
        end else begin
          out_cnt_d[i] = out_cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge hbm_clk) begin
    if (hbm_rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      out_vld_q <= out_vld_d;
      out_q     <= out_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  assign ar.m_axi_ARVALID = out_vld_q;
  assign ar.m_axi_ARADDR  = out_q.addr;
  assign ar.m_axi_ARID    = out_q.id;
  assign ar.m_axi_ARLEN   = out_q.len;
  assign credit_err       = err_q;

`ifdef HBM_RD_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];

  // A clear in the same cycle as a grant drops that grant from the count.
  always_ff @(posedge hbm_clk) begin
    if (hbm_rst || stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else if (grant) begin
      grant_cnt_q[gnt_idx] <= grant_cnt_q[gnt_idx] + 32'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*32 +: 32] = grant_cnt_q[i];
    end
  end
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign grant_cnt        = '0;
`endif

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
// Directed self-checking bench for hbm_rd_arbiter: main instance plus a MAX_OUTSTANDING=2 one.
module tb_hbm_rd_arbiter;
  import hbm_rd_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 33;
  localparam int unsigned IW = 6;
`ifdef HBM_RD_ARB_STATS_EN
  localparam int unsigned ExpG = 10;
`else
  localparam int unsigned ExpG = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             stats_clr;
  logic             credit_err, credit_err2;
  logic [NR*32-1:0] grant_cnt, grant_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  hbm_rd_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();
  hbm_rd_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus2 ();

  hbm_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(16)
  ) dut (
    .hbm_clk(clk), .hbm_rst(rst), .ar(bus), .stats_clr(stats_clr),
    .credit_err(credit_err), .grant_cnt(grant_cnt)
  );

  hbm_rd_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(2)
  ) dut2 (
    .hbm_clk(clk), .hbm_rst(rst), .ar(bus2), .stats_clr(stats_clr),
    .credit_err(credit_err2), .grant_cnt(grant_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stats_clr          = 1'b0;
    bus.s_axi_ARVALID  = '0;
    bus.s_axi_ARADDR   = '0;
    bus.s_axi_ARID     = '0;
    bus.s_axi_ARLEN    = '0;
    bus.m_axi_ARREADY  = 1'b1;
    bus.m_axi_RVALID   = 1'b0;
    bus.m_axi_RREADY   = 1'b0;
    bus.m_axi_RLAST    = 1'b0;
    bus.m_axi_RID      = '0;
    bus2.s_axi_ARVALID = '0;
    bus2.s_axi_ARADDR  = '0;
    bus2.s_axi_ARID    = '0;
    bus2.s_axi_ARLEN   = '0;
    bus2.m_axi_ARREADY = 1'b1;
    bus2.m_axi_RVALID  = 1'b0;
    bus2.m_axi_RREADY  = 1'b0;
    bus2.m_axi_RLAST   = 1'b0;
    bus2.m_axi_RID     = '0;
  endtask

  // Requests stay asserted during reset to show nothing is accepted then.
  task automatic do_reset();
    clear_inputs();
    rst                = 1'b1;
    bus.s_axi_ARVALID  = '1;
    bus2.s_axi_ARVALID = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mvalid", 64'(bus.m_axi_ARVALID), 64'd0);
    chk("rst_maddr", 64'(bus.m_axi_ARADDR), 64'd0);
    chk("rst_mid", 64'(bus.m_axi_ARID), 64'd0);
    chk("rst_mlen", 64'(bus.m_axi_ARLEN), 64'd0);
    chk("rst_sready", 64'(bus.s_axi_ARREADY), 64'd0);
    chk("rst_sready2", 64'(bus2.s_axi_ARREADY), 64'd0);
    chk("rst_credit_err", 64'(credit_err), 64'd0);
    chk("rst_grant_cnt", 64'(grant_cnt[63:32]), 64'd0);
    bus.s_axi_ARVALID  = '0;
    bus2.s_axi_ARVALID = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] addr, input int tag, input int len);
    bus.s_axi_ARADDR[i*AW +: AW] = addr;
    bus.s_axi_ARID[i*4 +: 4]     = 4'(tag);
    bus.s_axi_ARLEN[i*4 +: 4]    = 4'(len);
  endtask

  function automatic logic [5:0] exp_id(input int i, input int tag);
    return {i[1:0], tag[3:0]};
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Requester 0 alone: three back-to-back bursts, one cycle of latency.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      bus.s_axi_ARVALID = 4'b0001;
      set_req(0, AW'(33'h100 * (b + 1)), MEM_RD_A_TAG, 3);
      @(negedge clk);
      chk("t1_sready", 64'(bus.s_axi_ARREADY), 64'b0001);
      if (b > 0) begin
        chk("t1_mvalid", 64'(bus.m_axi_ARVALID), 64'd1);
        chk("t1_maddr", 64'(bus.m_axi_ARADDR), 64'h100 * b);
        chk("t1_mid", 64'(bus.m_axi_ARID), 64'b00_0001);
        chk("t1_mlen", 64'(bus.m_axi_ARLEN), 64'd3);
      end else begin
        chk("t1_mvalid_first", 64'(bus.m_axi_ARVALID), 64'd0);
      end
      tick();
    end
    bus.s_axi_ARVALID = '0;
    @(negedge clk);
    chk("t1_maddr_last", 64'(bus.m_axi_ARADDR), 64'h300);
    chk("t1_mid_last", 64'(bus.m_axi_ARID), 64'b00_0001);
    chk("t1_sready_idle", 64'(bus.s_axi_ARREADY), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_mvalid_drop", 64'(bus.m_axi_ARVALID), 64'd0);

    // All four valid: grant order 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, AW'(33'h1000 * (i + 1)), i + 1, i);
    bus.s_axi_ARVALID = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_sready", 64'(bus.s_axi_ARREADY), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk("t2_mid", 64'(bus.m_axi_ARID), 64'(exp_id((k - 1) % 4, ((k - 1) % 4) + 1)));
        chk("t2_maddr", 64'(bus.m_axi_ARADDR), 64'h1000 * (((k - 1) % 4) + 1));
      end
      tick();
    end

    // Backpressure: held burst from requester 1 must stay stable, no accepts.
    bus.m_axi_ARREADY = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("t3_mvalid", 64'(bus.m_axi_ARVALID), 64'd1);
      chk("t3_mid", 64'(bus.m_axi_ARID), 64'(exp_id(1, 2)));
      chk("t3_maddr", 64'(bus.m_axi_ARADDR), 64'h2000);
      chk("t3_mlen", 64'(bus.m_axi_ARLEN), 64'd1);
      chk("t3_sready", 64'(bus.s_axi_ARREADY), 64'd0);
      tick();
    end
    bus.m_axi_ARREADY = 1'b1;
    @(negedge clk);
    chk("t3_release_grant", 64'(bus.s_axi_ARREADY), 64'b0100);
    tick();
    bus.s_axi_ARVALID = '0;
    @(negedge clk);
    chk("t3_next_mid", 64'(bus.m_axi_ARID), 64'(exp_id(2, 3)));

    // Credit limit of 2 on the second instance.
    do_reset();
    bus2.s_axi_ARVALID = 4'b0001;
    @(negedge clk);
    chk("t4_c0", 64'(bus2.s_axi_ARREADY), 64'b0001);
    tick();
    @(negedge clk);
    chk("t4_c1", 64'(bus2.s_axi_ARREADY), 64'b0001);
    tick();
    @(negedge clk);
    chk("t4_c2_blocked", 64'(bus2.s_axi_ARREADY), 64'b0000);
    tick();
    bus2.s_axi_ARVALID = 4'b0011;
    @(negedge clk);
    chk("t4_c3_req1", 64'(bus2.s_axi_ARREADY), 64'b0010);
    tick();
    @(negedge clk);
    chk("t4_c4_req1", 64'(bus2.s_axi_ARREADY), 64'b0010);
    chk("t4_c4_mid", 64'(bus2.m_axi_ARID), 64'(exp_id(1, 0)));
    tick();
    bus2.m_axi_RVALID = 1'b1;
    bus2.m_axi_RREADY = 1'b1;
    bus2.m_axi_RLAST  = 1'b1;
    bus2.m_axi_RID    = 6'h00;
    @(negedge clk);
    chk("t4_c5_all_blocked", 64'(bus2.s_axi_ARREADY), 64'b0000);
    tick();
    bus2.m_axi_RVALID = 1'b0;
    bus2.m_axi_RLAST  = 1'b0;
    @(negedge clk);
    chk("t4_c6_req0_back", 64'(bus2.s_axi_ARREADY), 64'b0001);
    chk("t4_credit_err", 64'(credit_err2), 64'd0);
    tick();
    bus2.s_axi_ARVALID = '0;

    // Grant and release on the same counter; release on an empty counter.
    do_reset();
    set_req(2, AW'(33'h5000), MEM_RD_B_TAG, 7);
    bus.s_axi_ARVALID = 4'b0100;
    @(negedge clk);
    chk("t5_sready", 64'(bus.s_axi_ARREADY), 64'b0100);
    tick();
    bus.m_axi_RVALID = 1'b1;
    bus.m_axi_RREADY = 1'b1;
    bus.m_axi_RLAST  = 1'b1;
    bus.m_axi_RID    = 6'h20;
    @(negedge clk);
    chk("t5_cnt2_one", 64'(dut.out_cnt_q[2]), 64'd1);
    chk("t5_sready_again", 64'(bus.s_axi_ARREADY), 64'b0100);
    chk("t5_mid", 64'(bus.m_axi_ARID), 64'h22);
    tick();
    bus.s_axi_ARVALID = '0;
    bus.m_axi_RID     = 6'h30;
    @(negedge clk);
    chk("t5_cnt2_same", 64'(dut.out_cnt_q[2]), 64'd1);
    chk("t5_no_err_yet", 64'(credit_err), 64'd0);
    tick();
    bus.m_axi_RID = 6'h20;
    @(negedge clk);
    chk("t5_credit_err", 64'(credit_err), 64'd1);
    chk("t5_cnt3_zero", 64'(dut.out_cnt_q[3]), 64'd0);
    tick();
    bus.m_axi_RVALID = 1'b0;
    bus.m_axi_RLAST  = 1'b0;
    @(negedge clk);
    chk("t5_cnt2_zero", 64'(dut.out_cnt_q[2]), 64'd0);
    chk("t5_err_sticky", 64'(credit_err), 64'd1);

    // Grant statistics: ten grants to requester 1, then a clear that beats a grant.
    do_reset();
    set_req(1, AW'(33'h7000), MEM_RD_B_TAG, 0);
    bus.s_axi_ARVALID = 4'b0010;
    for (int g = 0; g < 10; g++) tick();
    bus.s_axi_ARVALID = '0;
    @(negedge clk);
    chk("t6_grant_cnt1", 64'(grant_cnt[63:32]), 64'(ExpG));
    chk("t6_grant_cnt0", 64'(grant_cnt[31:0]), 64'd0);
    tick();
    bus.s_axi_ARVALID = 4'b0010;
    stats_clr         = 1'b1;
    tick();
    bus.s_axi_ARVALID = '0;
    stats_clr         = 1'b0;
    @(negedge clk);
    chk("t6_clr_issued", 64'(bus.m_axi_ARVALID), 64'd1);
    chk("t6_after_clr", 64'(grant_cnt[63:32]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
